// File: rtl/debug_host.sv
// debug_host: initiator end of the UART debug protocol.
// Sends a 32-bit command word as 4 UART bytes (LSB first), then collects
// i_cmd_frames response frames of 7 bytes each and presents them in parallel.
module debug_host #(
  parameter int UART_BUS_SIZE  = 8,
  parameter int CMD_BUS_SIZE   = 32,
  parameter int FRAME_BUS_SIZE = 56,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  input  logic [CMD_BUS_SIZE-1:0]   i_cmd_word,
  input  logic [7:0]                i_cmd_frames,
  output logic                      o_cmd_ready,
  input  logic                      i_uart_full,
  output logic                      o_uart_wr,
  output logic [UART_BUS_SIZE-1:0]  o_uart_data_wr,
  input  logic                      i_uart_empty,
  output logic                      o_uart_rd,
  input  logic [UART_BUS_SIZE-1:0]  i_uart_data_rd,
  output logic                      o_frame_valid,
  output logic [FRAME_BUS_SIZE-1:0] o_frame_data,
  output logic [7:0]                o_frame_index,
  output logic                      o_done,
  output logic                      o_timeout,
  output logic [2:0]                o_state
);

  localparam int CMD_BYTES   = CMD_BUS_SIZE / UART_BUS_SIZE;
  localparam int FRAME_BYTES = FRAME_BUS_SIZE / UART_BUS_SIZE;
  localparam int CNT_W       = $clog2(FRAME_BYTES);
  localparam int TIMER_W     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    RECV_REQ = 3'd2,
    RECV_CAP = 3'd3,
    DONE     = 3'd4,
    TIMEOUT  = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]                frame_cnt_q, frame_cnt_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [CMD_BUS_SIZE-1:0]   word_q;
  logic [7:0]                frames_q;
  logic [FRAME_BUS_SIZE-1:0] shift_q;
  logic [FRAME_BUS_SIZE-1:0] frame_data_q;
  logic [7:0]                frame_index_q;
  logic                      frame_valid_q, done_q, timeout_q;

  logic                      wr_req, rd_req, latch_cmd, shift_en, frame_load;
  logic [CMD_BUS_SIZE-1:0]   cmd_shifted;

  // Next-state and FIFO strobe decode.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    timer_d     = timer_q;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    latch_cmd   = 1'b0;
    shift_en    = 1'b0;
    frame_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          latch_cmd  = 1'b1;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!i_uart_full) begin
          wr_req = 1'b1;
          if (byte_cnt_q == CNT_W'(CMD_BYTES - 1)) begin
            byte_cnt_d  = '0;
            frame_cnt_d = '0;
            timer_d     = '0;
            state_d     = (frames_q == 8'd0) ? DONE : RECV_REQ;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      RECV_REQ: begin
        if (!i_uart_empty) begin
          rd_req  = 1'b1;
          state_d = RECV_CAP;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RECV_CAP: begin
        shift_en = 1'b1;
        timer_d  = '0;
        if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
          frame_load  = 1'b1;
          byte_cnt_d  = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = (frame_cnt_q == frames_q - 8'd1) ? DONE : RECV_REQ;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = RECV_REQ;
        end
      end
      DONE:    state_d = IDLE;
      TIMEOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered result outputs, cleared by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      timer_q       <= '0;
      frame_data_q  <= '0;
      frame_index_q <= '0;
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timer_q       <= timer_d;
      frame_valid_q <= frame_load;
      done_q        <= (state_d == DONE);
      timeout_q     <= (state_d == TIMEOUT);
      if (frame_load) begin
        frame_data_q  <= {i_uart_data_rd, shift_q[FRAME_BUS_SIZE-1:UART_BUS_SIZE]};
        frame_index_q <= frame_cnt_q;
      end
    end
  end

  // Command latch and RX shift register; bytes enter at the top so the first
  // byte received ends up in bits [7:0] of the assembled frame.
  // NOTE: pure datapath registers are left out of reset; they are always
  // written before being used.
  always_ff @(posedge i_clk) begin
    if (latch_cmd) begin
      word_q   <= i_cmd_word;
      frames_q <= i_cmd_frames;
    end
    if (shift_en) begin
      shift_q <= {i_uart_data_rd, shift_q[FRAME_BUS_SIZE-1:UART_BUS_SIZE]};
    end
  end

  assign cmd_shifted    = word_q >> (int'(byte_cnt_q) * UART_BUS_SIZE);
  assign o_uart_data_wr = cmd_shifted[UART_BUS_SIZE-1:0];
  assign o_uart_wr      = wr_req && !i_reset;
  assign o_uart_rd      = rd_req && !i_reset;
  assign o_cmd_ready    = (state_q == IDLE);
  assign o_frame_valid  = frame_valid_q;
  assign o_frame_data   = frame_data_q;
  assign o_frame_index  = frame_index_q;
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_debug_host.sv
// Directed self-checking bench for debug_host with a short RX timeout.
module tb_debug_host;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [31:0] i_cmd_word = '0;
  logic [7:0]  i_cmd_frames = '0;
  logic        o_cmd_ready;
  logic        i_uart_full = 1'b0;
  logic        o_uart_wr;
  logic [7:0]  o_uart_data_wr;
  logic        rx_empty;
  logic        o_uart_rd;
  logic [7:0]  rx_data = '0;
  logic        o_frame_valid;
  logic [55:0] o_frame_data;
  logic [7:0]  o_frame_index;
  logic        o_done;
  logic        o_timeout;
  logic [2:0]  o_state;

  int passed = 0;
  int total  = 0;

  debug_host #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd_word     (i_cmd_word),
    .i_cmd_frames   (i_cmd_frames),
    .o_cmd_ready    (o_cmd_ready),
    .i_uart_full    (i_uart_full),
    .o_uart_wr      (o_uart_wr),
    .o_uart_data_wr (o_uart_data_wr),
    .i_uart_empty   (rx_empty),
    .o_uart_rd      (o_uart_rd),
    .i_uart_data_rd (rx_data),
    .o_frame_valid  (o_frame_valid),
    .o_frame_data   (o_frame_data),
    .o_frame_index  (o_frame_index),
    .o_done         (o_done),
    .o_timeout      (o_timeout),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: data appears the cycle after the read strobe.
  logic [7:0] rx_mem [64];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign rx_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (o_uart_rd) begin
      rx_data <= rx_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Output monitors, sampled mid-cycle.
  logic [7:0]  tx_log [64];
  int          tx_cyc [64];
  int          tx_cnt = 0;
  logic [55:0] fr_data [16];
  logic [7:0]  fr_idx [16];
  int          fr_cyc [16];
  int          fr_cnt = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          to_cnt = 0, to_cyc = 0;
  always @(negedge clk) begin
    if (o_uart_wr && tx_cnt < 64) begin
      tx_log[tx_cnt] = o_uart_data_wr;
      tx_cyc[tx_cnt] = cyc;
      tx_cnt++;
    end
    if (o_frame_valid && fr_cnt < 16) begin
      fr_data[fr_cnt] = o_frame_data;
      fr_idx[fr_cnt]  = o_frame_index;
      fr_cyc[fr_cnt]  = cyc;
      fr_cnt++;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic flush_rx();
    wr_ptr = rd_ptr;
  endtask

  task automatic issue(input logic [31:0] w, input logic [7:0] n, output int acc);
    i_cmd_word   = w;
    i_cmd_frames = n;
    i_cmd_valid  = 1'b1;
    acc          = cyc;
    tick();
    i_cmd_valid  = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int t0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0 || to_cnt > t0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (o_uart_wr !== 1'b0) $display("FAIL reset_wr_forced: got %b want 0", o_uart_wr); else passed++;
    tick(); tick();
    total++; if (o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", o_state); else passed++;
    total++; if (o_cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_cmd_ready); else passed++;
    total++; if ({o_frame_valid, o_done, o_timeout, o_uart_rd} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {o_frame_valid, o_done, o_timeout, o_uart_rd}); else passed++;
    total++; if (o_frame_data !== 56'd0) $display("FAIL reset_frame_data: got %h want 0", o_frame_data); else passed++;
    total++; if (o_frame_index !== 8'd0) $display("FAIL reset_frame_index: got %0d want 0", o_frame_index); else passed++;
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_tx_basic();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    int acc, tx0, d0;
    bit ok;
    tx0 = tx_cnt; d0 = done_cnt;
    issue(32'h11223344, 8'd0, acc);
    wait_end(d0, to_cnt, 40, ok);
    total++; if (!ok) $display("FAIL tx_basic_wait: got no done want done"); else passed++;
    total++; if (tx_cnt - tx0 != 4) $display("FAIL tx_basic_count: got %0d want 4", tx_cnt - tx0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_log[tx0 + i] !== exp[i]) $display("FAIL tx_basic_byte%0d: got %h want %h", i, tx_log[tx0 + i], exp[i]); else passed++;
    end
    total++; if (tx_cyc[tx0] != acc + 1 || tx_cyc[tx0 + 3] != acc + 4) $display("FAIL tx_basic_timing: got %0d..%0d want %0d..%0d", tx_cyc[tx0], tx_cyc[tx0 + 3], acc + 1, acc + 4); else passed++;
    total++; if (done_cyc != acc + 5) $display("FAIL tx_basic_done_cycle: got %0d want %0d", done_cyc, acc + 5); else passed++;
    tick();
    total++; if (o_cmd_ready !== 1'b1) $display("FAIL tx_basic_ready: got %b want 1", o_cmd_ready); else passed++;
  endtask

  task automatic test_tx_full();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    int acc, tx0, d0;
    bit ok;
    tick();
    tx0 = tx_cnt; d0 = done_cnt;
    issue(32'h11223344, 8'd0, acc);
    tick();
    i_uart_full = 1'b1;
    tick(); tick(); tick();
    i_uart_full = 1'b0;
    wait_end(d0, to_cnt, 40, ok);
    total++; if (!ok) $display("FAIL tx_full_wait: got no done want done"); else passed++;
    total++; if (tx_cnt - tx0 != 4) $display("FAIL tx_full_count: got %0d want 4", tx_cnt - tx0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_log[tx0 + i] !== exp[i]) $display("FAIL tx_full_byte%0d: got %h want %h", i, tx_log[tx0 + i], exp[i]); else passed++;
    end
    total++; if (tx_cyc[tx0 + 2] != acc + 6) $display("FAIL tx_full_held_cycle: got %0d want %0d", tx_cyc[tx0 + 2], acc + 6); else passed++;
    total++; if (done_cyc != acc + 8) $display("FAIL tx_full_done_cycle: got %0d want %0d", done_cyc, acc + 8); else passed++;
  endtask

  task automatic test_frames();
    int acc, f0, d0;
    bit ok;
    tick();
    flush_rx();
    for (int i = 1; i <= 15; i++) push_rx(8'(i));
    f0 = fr_cnt; d0 = done_cnt;
    issue(32'hA5A5_0002, 8'd2, acc);
    wait_end(d0, to_cnt, 100, ok);
    total++; if (!ok) $display("FAIL frames_wait: got no done want done"); else passed++;
    total++; if (fr_cnt - f0 != 2) $display("FAIL frames_count: got %0d want 2", fr_cnt - f0); else passed++;
    total++; if (fr_data[f0] !== 56'h07060504030201) $display("FAIL frames_data0: got %h want 07060504030201", fr_data[f0]); else passed++;
    total++; if (fr_idx[f0] !== 8'd0) $display("FAIL frames_idx0: got %0d want 0", fr_idx[f0]); else passed++;
    total++; if (fr_data[f0 + 1] !== 56'h0E0D0C0B0A0908) $display("FAIL frames_data1: got %h want 0e0d0c0b0a0908", fr_data[f0 + 1]); else passed++;
    total++; if (fr_idx[f0 + 1] !== 8'd1) $display("FAIL frames_idx1: got %0d want 1", fr_idx[f0 + 1]); else passed++;
    total++; if (fr_cyc[f0] != acc + 19) $display("FAIL frames_valid_cycle: got %0d want %0d", fr_cyc[f0], acc + 19); else passed++;
    total++; if (done_cyc != acc + 33) $display("FAIL frames_done_cycle: got %0d want %0d", done_cyc, acc + 33); else passed++;
    tick();
    total++; if (wr_ptr - rd_ptr != 1) $display("FAIL frames_extra_unread: got %0d left want 1", wr_ptr - rd_ptr); else passed++;
  endtask

  task automatic test_timeout();
    int acc, f0, d0, t0;
    bit ok;
    tick();
    flush_rx();
    push_rx(8'hC1); push_rx(8'hC2); push_rx(8'hC3);
    f0 = fr_cnt; d0 = done_cnt; t0 = to_cnt;
    issue(32'h0000_0001, 8'd1, acc);
    wait_end(d0, t0, 100, ok);
    total++; if (!ok) $display("FAIL timeout_wait: got no end want timeout"); else passed++;
    total++; if (to_cnt - t0 != 1 || done_cnt != d0) $display("FAIL timeout_pulses: got to=%0d done=%0d want to=1 done=0", to_cnt - t0, done_cnt - d0); else passed++;
    total++; if (to_cyc != acc + 27) $display("FAIL timeout_cycle: got %0d want %0d", to_cyc, acc + 27); else passed++;
    total++; if (fr_cnt != f0) $display("FAIL timeout_no_frame: got %0d frames want 0", fr_cnt - f0); else passed++;
    tick();
    total++; if (o_cmd_ready !== 1'b1 || o_state !== 3'd0) $display("FAIL timeout_idle: got ready=%b state=%0d want 1/0", o_cmd_ready, o_state); else passed++;
  endtask

  task automatic test_reset_mid();
    int acc, f0, d0, t0;
    bit ok, found;
    tick();
    flush_rx();
    for (int i = 0; i < 7; i++) push_rx(8'hA0 + 8'(i));
    d0 = done_cnt; t0 = to_cnt;
    issue(32'h0000_0005, 8'd1, acc);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_state == 3'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++; if (!found) $display("FAIL rstmid_reach_cap: got state %0d want 3", o_state); else passed++;
    i_reset = 1'b1;
    #1;
    total++; if (o_uart_rd !== 1'b0 || o_uart_wr !== 1'b0) $display("FAIL rstmid_strobes: got rd=%b wr=%b want 0/0", o_uart_rd, o_uart_wr); else passed++;
    @(posedge clk); #1;
    i_reset = 1'b0;
    total++; if (o_state !== 3'd0) $display("FAIL rstmid_state: got %0d want 0", o_state); else passed++;
    total++; if ({o_frame_valid, o_done, o_timeout} !== 3'b0) $display("FAIL rstmid_pulses: got %b want 000", {o_frame_valid, o_done, o_timeout}); else passed++;
    total++; if (o_frame_data !== 56'd0) $display("FAIL rstmid_frame_clear: got %h want 0", o_frame_data); else passed++;
    tick(); tick();
    total++; if (done_cnt != d0 || to_cnt != t0) $display("FAIL rstmid_no_end_pulse: got done=%0d to=%0d want 0/0", done_cnt - d0, to_cnt - t0); else passed++;
    flush_rx();
    for (int i = 1; i <= 7; i++) push_rx(8'h70 + 8'(i));
    f0 = fr_cnt;
    issue(32'h0000_0006, 8'd1, acc);
    wait_end(d0, t0, 60, ok);
    total++; if (!ok || done_cnt - d0 != 1) $display("FAIL rstmid_after_done: got done=%0d want 1", done_cnt - d0); else passed++;
    total++; if (fr_cnt - f0 != 1 || fr_data[f0] !== 56'h77767574737271) $display("FAIL rstmid_after_frame: got n=%0d data=%h want 1/77767574737271", fr_cnt - f0, fr_data[f0]); else passed++;
    total++; if (fr_idx[f0] !== 8'd0) $display("FAIL rstmid_after_idx: got %0d want 0", fr_idx[f0]); else passed++;
  endtask

  task automatic test_busy_valid();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    int acc, tx0, d0;
    bit ok;
    tick();
    tx0 = tx_cnt; d0 = done_cnt;
    i_cmd_word   = 32'h11223344;
    i_cmd_frames = 8'd0;
    i_cmd_valid  = 1'b1;
    acc = cyc;
    tick();
    i_cmd_word = 32'hDEADBEEF;
    tick(); tick(); tick();
    i_cmd_valid = 1'b0;
    wait_end(d0, to_cnt, 40, ok);
    for (int i = 0; i < 6; i++) tick();
    total++; if (!ok || done_cnt - d0 != 1) $display("FAIL busy_done: got %0d want 1", done_cnt - d0); else passed++;
    total++; if (tx_cnt - tx0 != 4) $display("FAIL busy_write_count: got %0d want 4", tx_cnt - tx0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_log[tx0 + i] !== exp[i]) $display("FAIL busy_byte%0d: got %h want %h", i, tx_log[tx0 + i], exp[i]); else passed++;
    end
    total++; if (o_state !== 3'd0) $display("FAIL busy_idle: got %0d want 0", o_state); else passed++;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_frames();
    test_timeout();
    test_reset_mid();
    test_busy_valid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
